lcd_bank_sched: RTL and testbench

Triple-buffer bank scheduler for the LCD frame buffer, in the `clk_sys` domain between the PPU pixel writer and the video-out reader. It decides which of three frame banks the writer fills and which bank the reader scans, and generates the write address and write enable. Finished frames are handed to the reader at its frame boundary, so the reader never scans a bank that is still being written (except in the optional early-read mode). Frames that are overwritten before being read are reported.

---
 rtl/lcd_bank_sched.sv | 175 +++++++++++++++++
 tb/tb_lcd_bank_sched.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bank_sched.sv
// lcd_bank_sched
// Triple-buffer bank scheduler between the PPU pixel writer and the video-out
// reader, all in clk_sys. Three frame banks rotate between three roles:
// being written, being read, and pending (a finished frame not yet shown).
// Finished frames go to the reader only at its frame boundary. A finished
// frame that is replaced before the reader takes it is reported as dropped.
//
// Optional feature macro: LCD_BANK_EARLY_RD_EN
//   When defined, a reader frame request with nothing pending may start
//   scanning the bank still being written. This needs the writer to be at
//   least EARLY_THRESH pixels ahead. rd_shared flags that mode. When the
//   macro is undefined, rd_shared is tied to 0.
//
// Ports:
//   clk_sys        in   clock
//   reset          in   synchronous, active-high
//   ce             in   pixel clock enable
//   wr_frame_start in   pulse: writer begins a frame
//   wr_pix         in   writer presents a pixel (qualified by ce)
//   wr_frame_end   in   pulse: writer completed a frame
//   wr_abort       in   pulse: LCD switched off mid-frame
//   rd_frame_req   in   pulse: reader about to start a frame
//   wr_bank        out  [1:0]  bank being written
//   wr_addr        out  [14:0] address of the current write pixel
//   wr_we          out  write strobe (combinational)
//   rd_bank        out  [1:0]  bank being read
//   rd_stale       out  reader is repeating the previous frame
//   rd_shared      out  reader scans the bank being written
//   frame_dropped  out  pulse: a finished frame was discarded unread
module lcd_bank_sched #(
  parameter int FRAME_PIX    = 23040,
  parameter int EARLY_THRESH = 9600
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce,
  input  logic        wr_frame_start,
  input  logic        wr_pix,
  input  logic        wr_frame_end,
  input  logic        wr_abort,
  input  logic        rd_frame_req,
  output logic [1:0]  wr_bank,
  output logic [14:0] wr_addr,
  output logic        wr_we,
  output logic [1:0]  rd_bank,
  output logic        rd_stale,
  output logic        rd_shared,
  output logic        frame_dropped
);

  localparam logic [14:0] FRAME_LIMIT = 15'(FRAME_PIX);

  logic [1:0]  wr_bank_reg, wr_bank_next;
  logic [1:0]  rd_bank_reg, rd_bank_next;
  logic [1:0]  pend_bank_reg, pend_bank_next;
  logic        pend_valid_reg, pend_valid_next;
  logic        rd_stale_reg, rd_stale_next;
  logic        rd_shared_reg, rd_shared_next;
  logic        dropped_reg, dropped_next;
  logic [14:0] wr_addr_reg, wr_addr_next;

  logic        end_evt;
  logic        early_ok;
  logic [1:0]  free_bank;

  // An abort cancels a coinciding frame end.
  assign end_evt = wr_frame_end & ~wr_abort;

  assign wr_we = ce & wr_pix & (wr_addr_reg < FRAME_LIMIT);

  // While shared, rd_bank equals wr_bank, so the free bank is the one held
  // by neither the writer nor the pending slot.
  assign free_bank = rd_shared_reg ? (2'd3 - wr_bank_reg - pend_bank_reg)
                                   : (2'd3 - wr_bank_reg - rd_bank_reg);

`ifdef LCD_BANK_EARLY_RD_EN
  localparam logic [14:0] EARLY_LIMIT = 15'(EARLY_THRESH);
  assign early_ok = (wr_addr_reg >= EARLY_LIMIT);

  always_ff @(posedge clk_sys) begin
    if (reset) rd_shared_reg <= 1'b0;
    else       rd_shared_reg <= rd_shared_next;
  end
`else
  logic unused_cfg;
  assign early_ok      = 1'b0;
  assign rd_shared_reg = 1'b0;
  assign unused_cfg    = rd_shared_next ^ (|15'(EARLY_THRESH));
`endif

  always_comb begin
    wr_bank_next    = wr_bank_reg;
    rd_bank_next    = rd_bank_reg;
    pend_bank_next  = pend_bank_reg;
    pend_valid_next = pend_valid_reg;
    rd_stale_next   = rd_stale_reg;
    rd_shared_next  = rd_shared_reg;
    dropped_next    = 1'b0;
    wr_addr_next    = wr_addr_reg;

    if (wr_abort || end_evt || wr_frame_start) begin
      wr_addr_next = '0;
    end else if (wr_we) begin
      wr_addr_next = wr_addr_reg + 15'd1;
    end

    if (end_evt && rd_shared_reg) begin
      // The reader already holds the finished frame, so the writer moves on
      // to the free bank. A coinciding request just re-reads that bank.
      wr_bank_next   = free_bank;
      rd_shared_next = 1'b0;
      if (rd_frame_req) rd_stale_next = 1'b1;
    end else if (end_evt && rd_frame_req) begin
      // The reader takes the newest frame directly. Any pending frame is older.
      rd_bank_next  = wr_bank_reg;
      rd_stale_next = 1'b0;
      if (pend_valid_reg) begin
        wr_bank_next    = pend_bank_reg;
        pend_bank_next  = rd_bank_reg;
        pend_valid_next = 1'b0;
        dropped_next    = 1'b1;
      end else begin
        wr_bank_next = rd_bank_reg;
      end
    end else if (end_evt) begin
      // The finished frame becomes pending, and the writer reuses the old
      // pending bank. If that bank still held an unread frame, it is lost.
      wr_bank_next    = pend_bank_reg;
      pend_bank_next  = wr_bank_reg;
      pend_valid_next = 1'b1;
      dropped_next    = pend_valid_reg;
    end else if (rd_frame_req) begin
      if (pend_valid_reg) begin
        rd_bank_next    = pend_bank_reg;
        pend_bank_next  = rd_bank_reg;
        pend_valid_next = 1'b0;
        rd_stale_next   = 1'b0;
      end else if (early_ok) begin
        rd_bank_next   = wr_bank_reg;
        rd_shared_next = 1'b1;
        rd_stale_next  = 1'b0;
      end else begin
        rd_stale_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_bank_reg    <= 2'd0;
      rd_bank_reg    <= 2'd1;
      pend_bank_reg  <= 2'd2;
      pend_valid_reg <= 1'b0;
      rd_stale_reg   <= 1'b1;
      dropped_reg    <= 1'b0;
      wr_addr_reg    <= '0;
    end else begin
      wr_bank_reg    <= wr_bank_next;
      rd_bank_reg    <= rd_bank_next;
      pend_bank_reg  <= pend_bank_next;
      pend_valid_reg <= pend_valid_next;
      rd_stale_reg   <= rd_stale_next;
      dropped_reg    <= dropped_next;
      wr_addr_reg    <= wr_addr_next;
    end
  end

  assign wr_bank       = wr_bank_reg;
  assign rd_bank       = rd_bank_reg;
  assign wr_addr       = wr_addr_reg;
  assign rd_stale      = rd_stale_reg;
  assign rd_shared     = rd_shared_reg;
  assign frame_dropped = dropped_reg;

endmodule

// File: tb/tb_lcd_bank_sched.sv
module tb_lcd_bank_sched;
  localparam int FP = 23040;
  localparam int TH = 9600;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic        wr_frame_start = 1'b0;
  logic        wr_pix = 1'b0;
  logic        wr_frame_end = 1'b0;
  logic        wr_abort = 1'b0;
  logic        rd_frame_req = 1'b0;
  logic [1:0]  wr_bank;
  logic [14:0] wr_addr;
  logic        wr_we;
  logic [1:0]  rd_bank;
  logic        rd_stale;
  logic        rd_shared;
  logic        frame_dropped;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  lcd_bank_sched #(.FRAME_PIX(FP), .EARLY_THRESH(TH)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce(ce),
    .wr_frame_start(wr_frame_start), .wr_pix(wr_pix),
    .wr_frame_end(wr_frame_end), .wr_abort(wr_abort),
    .rd_frame_req(rd_frame_req), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .wr_we(wr_we), .rd_bank(rd_bank), .rd_stale(rd_stale),
    .rd_shared(rd_shared), .frame_dropped(frame_dropped)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  // Role model: which bank is held by the writer, the reader and the pending slot.
  int m_wr, m_rd, m_pend, m_addr;
  bit m_pv, m_stale, m_shared, m_drop, ready;
`ifdef LCD_BANK_EARLY_RD_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  function automatic int unheld(input int a, input int b);
    for (int k = 0; k < 3; k++) if (k != a && k != b) return k;
    return -1;
  endfunction

  always @(posedge clk_sys) begin
    if (reset) begin
      m_wr = 0; m_rd = 1; m_pend = 2; m_pv = 0; m_addr = 0;
      m_stale = 1; m_shared = 0; m_drop = 0; ready = 1;
    end else if (ready) begin
      bit e;
      int o_addr;
      e = wr_frame_end && !wr_abort;
      o_addr = m_addr;
      m_drop = 0;
      if (wr_abort || e || wr_frame_start) m_addr = 0;
      else if (ce && wr_pix && m_addr < FP) m_addr++;
      if (e && m_shared) begin
        m_wr = unheld(m_wr, m_pend); m_shared = 0;
        if (rd_frame_req) m_stale = 1;
      end else if (e && rd_frame_req) begin
        int old_rd;
        old_rd = m_rd; m_rd = m_wr; m_stale = 0;
        if (m_pv) begin m_wr = m_pend; m_pend = old_rd; m_pv = 0; m_drop = 1; end
        else m_wr = old_rd;
      end else if (e) begin
        int t;
        t = m_wr; m_wr = m_pend; m_pend = t; m_drop = m_pv; m_pv = 1;
      end else if (rd_frame_req) begin
        if (m_pv) begin
          int t;
          t = m_rd; m_rd = m_pend; m_pend = t; m_pv = 0; m_stale = 0;
        end else if (EARLY && o_addr >= TH) begin
          m_rd = m_wr; m_shared = 1; m_stale = 0;
        end else m_stale = 1;
      end
    end
  end

  always @(negedge clk_sys) begin
    if (ready) begin
      chk("wr_bank", wr_bank, m_wr);
      chk("rd_bank", rd_bank, m_rd);
      chk("wr_addr", wr_addr, m_addr);
      chk("rd_stale", rd_stale, m_stale);
      chk("rd_shared", rd_shared, m_shared);
      chk("frame_dropped", frame_dropped, m_drop);
      chk("wr_we", wr_we, (ce && wr_pix && m_addr < FP) ? 1 : 0);
    end
  end

  // One cycle with the given pulses, then all pulses are released.
  task automatic cyc(input bit s, input bit e, input bit a, input bit r);
    wr_frame_start = s; wr_frame_end = e; wr_abort = a; rd_frame_req = r;
    @(posedge clk_sys); #1;
    wr_frame_start = 0; wr_frame_end = 0; wr_abort = 0; rd_frame_req = 0;
  endtask

  task automatic pix(input int n, input bit half_ce, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      wr_pix = 1'b1;
      ce = half_ce ? i[0] : 1'b1;
      #1;
      cnt += int'(wr_we);
      @(posedge clk_sys); #1;
    end
    wr_pix = 1'b0; ce = 1'b0;
  endtask

  initial begin
    int cnt;
    reset = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1 reset = 1'b0;
    chk("rst_wr_bank", wr_bank, 0); chk("rst_rd_bank", rd_bank, 1);
    chk("rst_stale", rd_stale, 1); chk("rst_addr", wr_addr, 0);
    chk("rst_drop", frame_dropped, 0); chk("rst_we", wr_we, 0);
    $display("reset: wr_bank=%0d rd_bank=%0d", wr_bank, rd_bank);

    cyc(1, 0, 0, 0);
    pix(23050, 0, cnt);
    chk("we_count", cnt, 23040); chk("addr_sat", wr_addr, 23040);
    $display("full frame: %0d strobes, addr=%0d", cnt, wr_addr);
    cyc(0, 1, 0, 0);
    chk("end1_wr_bank", wr_bank, 2); chk("end1_addr", wr_addr, 0);
    $display("frame end: wr_bank=%0d", wr_bank);
    cyc(0, 0, 0, 1);
    chk("req1_rd_bank", rd_bank, 0); chk("req1_wr_bank", wr_bank, 2);
    chk("req1_stale", rd_stale, 0);
    $display("read req: rd_bank=%0d stale=%0d", rd_bank, rd_stale);

    cyc(1, 0, 0, 0);
    pix(100, 1, cnt);
    chk("we_half_ce", cnt, 50); chk("addr_half_ce", wr_addr, 50);
    cyc(0, 1, 0, 0);
    chk("end2_wr_bank", wr_bank, 1); chk("end2_drop", frame_dropped, 0);
    cyc(1, 0, 0, 0);
    pix(30, 0, cnt);
    cyc(0, 1, 0, 0);
    chk("end3_drop", frame_dropped, 1); chk("end3_wr_bank", wr_bank, 2);
    $display("second end without read: drop=%0d", frame_dropped);
    cyc(0, 0, 0, 1);
    chk("req2_rd_bank", rd_bank, 1); chk("req2_stale", rd_stale, 0);
    $display("read req: rd_bank=%0d", rd_bank);

    cyc(1, 0, 0, 0); pix(40, 0, cnt); cyc(0, 1, 0, 0);
    chk("end4_wr_bank", wr_bank, 0);
    cyc(1, 0, 0, 0); pix(40, 0, cnt); cyc(0, 1, 0, 1);
    chk("both_pv_rd", rd_bank, 0); chk("both_pv_wr", wr_bank, 2);
    chk("both_pv_drop", frame_dropped, 1);
    $display("end+req with pending: rd=%0d wr=%0d drop=%0d", rd_bank, wr_bank, frame_dropped);
    cyc(0, 0, 0, 1);
    chk("req3_stale", rd_stale, 1); chk("req3_rd", rd_bank, 0);
    $display("read req with nothing pending: stale=%0d", rd_stale);
    cyc(1, 0, 0, 0); pix(10, 0, cnt); cyc(0, 1, 0, 1);
    chk("both_np_rd", rd_bank, 2); chk("both_np_wr", wr_bank, 0);
    chk("both_np_stale", rd_stale, 0);
    $display("end+req without pending: rd=%0d wr=%0d", rd_bank, wr_bank);

    cyc(1, 0, 0, 0); pix(5000, 0, cnt);
    chk("pre_abort_addr", wr_addr, 5000);
    cyc(0, 0, 1, 0);
    chk("abort_addr", wr_addr, 0); chk("abort_wr", wr_bank, 0);
    chk("abort_rd", rd_bank, 2); chk("abort_drop", frame_dropped, 0);
    cyc(0, 0, 0, 1);
    chk("abort_req_stale", rd_stale, 1);
    $display("abort at 5000: addr=%0d stale after req=%0d", wr_addr, rd_stale);
    cyc(1, 0, 0, 0); pix(20, 0, cnt); cyc(0, 1, 1, 0);
    chk("abort_end_wr", wr_bank, 0); chk("abort_end_addr", wr_addr, 0);
    $display("abort+end: wr_bank=%0d", wr_bank);
    cyc(1, 0, 0, 0); pix(20, 0, cnt); cyc(1, 1, 0, 0);
    chk("start_end_wr", wr_bank, 1); chk("start_end_addr", wr_addr, 0);
    $display("start+end: wr_bank=%0d addr=%0d", wr_bank, wr_addr);

    cyc(1, 0, 0, 0); pix(10, 0, cnt);
    reset = 1'b1; @(posedge clk_sys); #1 reset = 1'b0;
    chk("mid_rst_wr", wr_bank, 0); chk("mid_rst_rd", rd_bank, 1);
    chk("mid_rst_stale", rd_stale, 1); chk("mid_rst_addr", wr_addr, 0);
    $display("mid-frame reset: wr=%0d rd=%0d", wr_bank, rd_bank);

`ifdef LCD_BANK_EARLY_RD_EN
    cyc(1, 0, 0, 0); pix(9600, 0, cnt);
    cyc(0, 0, 0, 1);
    chk("early_rd", rd_bank, 0); chk("early_shared", rd_shared, 1);
    chk("early_stale", rd_stale, 0);
    $display("early read at 9600: rd=%0d shared=%0d", rd_bank, rd_shared);
    pix(100, 0, cnt);
    cyc(0, 1, 0, 0);
    chk("early_end_wr", wr_bank, 1); chk("early_end_shared", rd_shared, 0);
    chk("early_end_rd", rd_bank, 0);
    cyc(0, 0, 0, 1);
    chk("early_end_nopend", rd_stale, 1);
    $display("end after early read: wr=%0d shared=%0d", wr_bank, rd_shared);
    cyc(1, 0, 0, 0); pix(9599, 0, cnt);
    cyc(0, 0, 0, 1);
    chk("early_9599_stale", rd_stale, 1); chk("early_9599_shared", rd_shared, 0);
    $display("read req at 9599: stale=%0d", rd_stale);
`endif

    repeat (2) @(posedge clk_sys);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
